// File: rtl/keccak_pkg.sv
// Shared constants, slice bit mapping and FSM states for the Keccak theta datapath.
// No logic; imported by the theta column-parity blocks.
package keccak_pkg;

  localparam int SLICE_BITS = 25;
  localparam int ROW        = 5;

  typedef enum logic {
    LOAD,
    EMIT
  } state_t;

  // A[x][y] lives at bit 24-(5*y+x) of a slice
  function automatic int bit_idx(input int x, input int y);
    return SLICE_BITS - 1 - (ROW * y + x);
  endfunction

endpackage

// File: rtl/slice_col_parity.sv
// Column parity of one 25-bit state slice: col_par[x] = XOR over y of A[x][y].
// Latency: combinational. Backpressure: none (pure function of the slice).
module slice_col_parity
  import keccak_pkg::*;
(
  input  logic [SLICE_BITS-1:0] slice,
  output logic [ROW-1:0]        col_par
);

  always_comb begin
    col_par = '0;
    for (int x = 0; x < ROW; x++) begin
      for (int y = 0; y < ROW; y++) begin
        col_par[x] = col_par[x] ^ slice[bit_idx(x, y)];
      end
    end
  end

endmodule

// File: rtl/theta_parity_stream.sv
// Streams W slices in, stores their column parities, then streams out theta D per slice.
// Latency: out_valid rises the cycle after the W-th input. Backpressure: output held while !out_ready; no input in EMIT.
module theta_parity_stream
  import keccak_pkg::*;
#(
  parameter  int W  = 64,
  localparam int ZW = $clog2(W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SLICE_BITS-1:0] in_slice,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ROW-1:0]        out_d,
  output logic [ZW-1:0]         out_z,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ZW-1:0] LAST_Z = ZW'(W - 1);

  state_t         state, state_nxt;
  logic [ZW-1:0]  load_cnt, emit_cnt, prev_z;
  logic [ROW-1:0] store [W];
  logic [ROW-1:0] c_in, c_cur, c_prev, d_raw;
  logic           init_q, done_q;
  logic           in_xfer, out_xfer, last_load, last_emit;

  slice_col_parity u_col_par (
    .slice   (in_slice),
    .col_par (c_in)
  );

  assign last_load = (load_cnt == LAST_Z);
  assign last_emit = (emit_cnt == LAST_Z);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // init_q keeps in_ready low for the reset cycle itself
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = init_q;
        if (in_valid && init_q && last_load) state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready && last_emit) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= LOAD;
      load_cnt <= '0;
      emit_cnt <= '0;
      init_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < W; i++) store[i] <= '0;
    end else begin
      state  <= state_nxt;
      init_q <= 1'b1;
      done_q <= out_xfer & last_emit;
      if (in_xfer) begin
        store[load_cnt] <= c_in;
        load_cnt        <= last_load ? '0 : load_cnt + 1'b1;
        if (last_load) emit_cnt <= '0;
      end
      // explicit wrap keeps non-power-of-two W legal
      if (out_xfer) emit_cnt <= last_emit ? '0 : emit_cnt + 1'b1;
    end
  end

  assign prev_z = (emit_cnt == '0) ? LAST_Z : emit_cnt - 1'b1;
  assign c_cur  = store[emit_cnt];
  assign c_prev = store[prev_z];

  always_comb begin
    d_raw = '0;
    for (int x = 0; x < ROW; x++) begin
      d_raw[x] = c_cur[(x + 4) % ROW] ^ c_prev[(x + 1) % ROW];
    end
  end

  assign out_d = out_valid ? d_raw : '0;
  assign out_z = emit_cnt;
  assign done  = done_q;

endmodule
